timer_dev: RTL and testbench
============================

# timer_dev

Memory-mapped countdown timer that acts as a responder on the CPU data bus, the far end of the `m_data_addr` / `m_data_wdata` / `m_data_byteen` / `m_data_rdata` interface driven by the pipeline's MEM stage. It decodes a 16-byte window, accepts byte-enabled register writes and returns read data combinationally in the same cycle. An internal FSM reloads, counts down and raises an interrupt in one-shot or auto-reload mode.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00, base of the register window; bits [3:0] are ignored.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0).
- `addr` input 32: data-bus byte address from MEM stage.
- `wdata` input 32: write data, already lane-aligned.
- `byteen` input 4: byte write enables; all-zero means read or no access.
- `rdata` output 32: read data, combinational.
- `irq` output 1: interrupt request, level.

## Operation
- Select: `sel = (addr[31:4] == BASE_ADDR[31:4])`. Word index is `addr[3:2]`.
- Registers:
  - 0x0 CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask), [31:4] read 0.
  - 0x4 PRESET: 32-bit reload value, R/W.
  - 0x8 COUNT: read-only; writes ignored.
  - 0xC reads 0; writes ignored.
- Write: when `sel` and `byteen[i]`, byte i of the target register takes `wdata[8i+7:8i]` at the rising edge.
- Read: `rdata` is the selected register while `sel`, otherwise 0. No state change on read.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT: if !EN, go to IDLE and hold COUNT. Else if COUNT > 1, decrement. Else COUNT <= 0, set flag, go to INT. COUNT == 0 on entry counts as expired.
  - INT: MODE 00 clears EN and goes to IDLE, with the flag held. MODE 01 clears the flag and goes to LOAD.
- `irq = flag & IM`. The flag clears on any CTRL write or on reset.
- Simultaneous events:
  - A bus write to CTRL in the same edge as the INT hardware clear of EN: the bus write wins.
  - A PRESET write during CNT does not affect the running COUNT. It is used at the next LOAD.
- Unsigned arithmetic. COUNT never wraps below 0.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, flag 0, `irq`=0. `rdata`=0 unless selected.
- Reset asserted mid-count returns everything to reset values immediately (asynchronous). The FSM resumes in IDLE after release.
- Write latency: register updates at the edge on which `addr`/`byteen` are presented. Readback of the new value is available the following cycle.
- Read latency: 0 cycles, combinational from `addr`.
- Count sequence, with the CTRL write (EN=1) at edge E0 and PRESET = N ≥ 1:
  - LOAD at E1.
  - COUNT=N at E2.
  - COUNT=0, state INT and flag=1 at E2+N.
- N=0 enters INT at E3.
- Auto-reload: period N+2 cycles. `irq` is high for 1 cycle per period.

## Configuration
- `TIMER_IRQ_EN` defined: flag, IM bit and `irq` are implemented as above.
- `TIMER_IRQ_EN` not defined:
  - `irq` is tied 0.
  - CTRL[3] reads 0 and is not writable.
  - The flag register is removed.
  - The FSM and counting behaviour are otherwise unchanged.

## Structure
- Shared package `timer_pkg`:
  - Register offsets (CTRL_OFF, PRESET_OFF, COUNT_OFF).
  - CTRL bit positions.
  - MODE encodings.
  - State enum `timer_state_t`.
- Sub-module `timer_core`: FSM, COUNT register and flag. Inputs are EN, MODE, PRESET and a CTRL-write strobe; outputs are COUNT, flag and the EN-clear request.
- The top level `timer_dev` holds the address decode, byte-lane merge, CTRL/PRESET registers and read mux.

## Test plan
- Reset: hold `reset`=0 with traffic on the bus. Required: `rdata`=0 for all addresses and `irq`=0. After release, read CTRL/PRESET/COUNT = 0.
- Byte-lane write: write 32'hAABBCCDD to PRESET with `byteen`=4'b0101. Required: PRESET reads 32'h00BB00DD. A write to COUNT leaves it 0.
- One-shot: PRESET=5, then CTRL=32'h9 (EN, IM) at E0. Required:
  - COUNT reads 5 at E2 and 1 at E6.
  - `irq`=1 at E7 and held.
  - CTRL[0] reads 0 at E8.
  - Writing CTRL=0 drops `irq`.
- Auto-reload: PRESET=3, CTRL=32'hB. Required: `irq` single-cycle pulses every 5 cycles, and COUNT cycles 3,2,1,0.
- Disable mid-count: PRESET=100, EN. Clear EN when COUNT=40. Required: state IDLE, COUNT held at 40, no `irq`.
- Mid-operation reset and decode: assert reset at COUNT=10. Required: everything reads 0. Separately, an access at BASE_ADDR+32'h10 leaves all registers unchanged and `rdata`=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer (timer_dev).
// Optional interrupt logic is enabled by defining TIMER_IRQ_EN.
package timer_pkg;

   localparam logic [3:0] CTRL_OFF   = 4'h0;
   localparam logic [3:0] PRESET_OFF = 4'h4;
   localparam logic [3:0] COUNT_OFF  = 4'h8;

   localparam int unsigned CTRL_EN_BIT   = 0;
   localparam int unsigned CTRL_MODE_LSB = 1;
   localparam int unsigned CTRL_IM_BIT   = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CNT,
      ST_INT
   } timer_state_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old_val;
      for (int unsigned i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/timer_core.sv
// Timer FSM with COUNT register and expiry flag.
// The flag register exists only when TIMER_IRQ_EN is defined.
module timer_core
   import timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [31:0] preset,
   input  logic        ctrl_wr,
   output logic [31:0] count,
   output logic        flag,
   output logic        en_clr
);

   timer_state_t state;
   logic         auto_mode;

   // MODE 1x behaves as one-shot, so only the exact auto encoding reloads
   assign auto_mode = (mode == MODE_AUTO);
   assign en_clr    = (state == ST_INT) && !auto_mode;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         count <= '0;
`ifdef TIMER_IRQ_EN
         flag  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (en) state <= ST_LOAD;
            ST_LOAD: begin
               count <= preset;
               state <= ST_CNT;
            end
            ST_CNT: begin
               if (!en) begin
                  state <= ST_IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  count <= '0;
                  state <= ST_INT;
`ifdef TIMER_IRQ_EN
                  flag  <= 1'b1;
`endif
               end
            end
            ST_INT: begin
               if (auto_mode) begin
                  state <= ST_LOAD;
`ifdef TIMER_IRQ_EN
                  flag  <= 1'b0;
`endif
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
`ifdef TIMER_IRQ_EN
         if (ctrl_wr) flag <= 1'b0;
`endif
      end
   end

`ifndef TIMER_IRQ_EN
   logic unused_ctrl_wr;
   assign unused_ctrl_wr = ctrl_wr;
   assign flag = 1'b0;
`endif

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: bus decode, CTRL/PRESET registers, read mux.
// Define TIMER_IRQ_EN to implement the IM bit and the irq output.
module timer_dev
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   output logic [31:0] rdata,
   output logic        irq
);

   logic        sel;
   logic [3:0]  off;
   logic        ctrl_wr;
   logic        preset_wr;
   logic        ctrl_en;
   logic [1:0]  ctrl_mode;
   logic        ctrl_im;
   logic [31:0] preset;
   logic [31:0] count;
   logic        flag;
   logic        en_clr;
   logic        unused_addr;

   assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
   assign off         = {addr[3:2], 2'b00};
   assign ctrl_wr     = sel && (|byteen) && (off == CTRL_OFF);
   assign preset_wr   = sel && (|byteen) && (off == PRESET_OFF);
   assign unused_addr = ^addr[1:0];

   // Only byte 0 of CTRL holds state; a bus write to it overrides the INT-state EN clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= MODE_ONESHOT;
         preset    <= '0;
      end else begin
         if (ctrl_wr && byteen[0]) begin
            ctrl_en   <= wdata[CTRL_EN_BIT];
            ctrl_mode <= wdata[CTRL_MODE_LSB +: 2];
         end else if (en_clr) begin
            ctrl_en <= 1'b0;
         end
         if (preset_wr) preset <= merge_bytes(preset, wdata, byteen);
      end
   end

`ifdef TIMER_IRQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                     ctrl_im <= 1'b0;
      else if (ctrl_wr && byteen[0])  ctrl_im <= wdata[CTRL_IM_BIT];
   end
   assign irq = flag & ctrl_im;
`else
   logic unused_flag;
   assign unused_flag = flag;
   assign ctrl_im     = 1'b0;
   assign irq         = 1'b0;
`endif

   timer_core u_core (
      .clk     (clk),
      .reset   (reset),
      .en      (ctrl_en),
      .mode    (ctrl_mode),
      .preset  (preset),
      .ctrl_wr (ctrl_wr),
      .count   (count),
      .flag    (flag),
      .en_clr  (en_clr)
   );

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (off)
            CTRL_OFF:   rdata = {28'b0, ctrl_im, ctrl_mode, ctrl_en};
            PRESET_OFF: rdata = preset;
            COUNT_OFF:  rdata = count;
            default:    rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev; irq expectations follow TIMER_IRQ_EN.
module tb_timer_dev;

   localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef TIMER_IRQ_EN
   localparam bit HAS_IRQ = 1'b1;
`else
   localparam bit HAS_IRQ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  byteen;
   logic [31:0] rdata;
   logic        irq;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   timer_dev #(.BASE_ADDR(BASE)) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .wdata  (wdata),
      .byteen (byteen),
      .rdata  (rdata),
      .irq    (irq)
   );

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      addr = a; wdata = d; byteen = be;
      @(negedge clk);
      byteen = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      addr = a; byteen = '0;
      #1;
      d = rdata;
   endtask

   task automatic test_reset;
      logic [31:0] got, ev;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         addr = BASE + 32'(4 * (i % 4)); wdata = $urandom; byteen = 4'hF;
         #1;
         exp_q.push_back('0);
         exp_q.push_back('0);
         got = rdata; ev = exp_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL reset_rdata got %h exp %h", got, ev); end
         got = {31'b0, irq}; ev = exp_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL reset_irq got %h exp %h", got, ev); end
      end
      @(negedge clk);
      byteen = '0;
      reset = 1'b1;
      tick(1);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('0);
         bus_read(BASE + 32'(4 * i), got); ev = exp_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL reset_release_reg%0d got %h exp %h", i, got, ev); end
      end
   endtask

   task automatic test_byte_lane;
      logic [31:0] got, ev;
      bus_write(BASE + 32'h4, 32'hAABBCCDD, 4'b0101);
      bus_write(BASE + 32'h8, 32'hFFFFFFFF, 4'hF);
      bus_write(BASE + 32'hC, 32'hFFFFFFFF, 4'hF);
      exp_q.push_back(32'h00BB00DD);
      exp_q.push_back('0);
      exp_q.push_back('0);
      bus_read(BASE + 32'h4, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL byte_lane_preset got %h exp %h", got, ev); end
      bus_read(BASE + 32'h8, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL count_write_ignored got %h exp %h", got, ev); end
      bus_read(BASE + 32'hC, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL reg_c_reads_zero got %h exp %h", got, ev); end
   endtask

   task automatic test_oneshot;
      logic [31:0] got, ev;
      bus_write(BASE + 32'h4, 32'd5, 4'hF);
      bus_write(BASE, 32'h9, 4'hF);           // E0
      tick(2);                                // after E2
      exp_q.push_back(32'd5);
      bus_read(BASE + 32'h8, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL oneshot_count_e2 got %h exp %h", got, ev); end
      tick(4);                                // after E6
      exp_q.push_back(32'd1);
      exp_q.push_back('0);
      bus_read(BASE + 32'h8, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL oneshot_count_e6 got %h exp %h", got, ev); end
      got = {31'b0, irq}; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL oneshot_irq_e6 got %h exp %h", got, ev); end
      tick(1);                                // after E7
      exp_q.push_back({31'b0, HAS_IRQ});
      exp_q.push_back('0);
      got = {31'b0, irq}; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL oneshot_irq_e7 got %h exp %h", got, ev); end
      bus_read(BASE + 32'h8, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL oneshot_count_e7 got %h exp %h", got, ev); end
      tick(1);                                // after E8
      exp_q.push_back(HAS_IRQ ? 32'h8 : 32'h0);
      exp_q.push_back({31'b0, HAS_IRQ});
      bus_read(BASE, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL oneshot_ctrl_e8 got %h exp %h", got, ev); end
      got = {31'b0, irq}; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL oneshot_irq_held got %h exp %h", got, ev); end
      bus_write(BASE, 32'h0, 4'hF);
      exp_q.push_back('0);
      got = {31'b0, irq}; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL oneshot_irq_cleared got %h exp %h", got, ev); end
   endtask

   task automatic test_zero_preset;
      logic [31:0] got, ev;
      bus_write(BASE + 32'h4, 32'd0, 4'hF);
      bus_write(BASE, 32'hD, 4'hF);           // MODE=10 must behave as one-shot
      tick(2);
      exp_q.push_back('0);
      got = {31'b0, irq}; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL n0_irq_e2 got %h exp %h", got, ev); end
      tick(1);
      exp_q.push_back({31'b0, HAS_IRQ});
      exp_q.push_back('0);
      got = {31'b0, irq}; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL n0_irq_e3 got %h exp %h", got, ev); end
      bus_read(BASE + 32'h8, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL n0_count_e3 got %h exp %h", got, ev); end
      tick(1);
      exp_q.push_back(HAS_IRQ ? 32'hC : 32'h4);
      bus_read(BASE, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL n0_ctrl_e4 got %h exp %h", got, ev); end
      bus_write(BASE, 32'h0, 4'hF);
   endtask

   task automatic test_auto_reload;
      logic [31:0] got, ev, ec;
      bus_write(BASE + 32'h4, 32'd3, 4'hF);
      bus_write(BASE, 32'hB, 4'hF);
      for (int k = 1; k <= 22; k++) begin
         tick(1);
         if (k < 2) ec = '0;
         else case ((k - 2) % 5)
            0: ec = 32'd3;
            1: ec = 32'd2;
            2: ec = 32'd1;
            default: ec = 32'd0;
         endcase
         exp_q.push_back(ec);
         exp_q.push_back({31'b0, HAS_IRQ && (k >= 5) && ((k - 5) % 5 == 0)});
         bus_read(BASE + 32'h8, got); ev = exp_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL auto_count_k%0d got %h exp %h", k, got, ev); end
         got = {31'b0, irq}; ev = exp_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL auto_irq_k%0d got %h exp %h", k, got, ev); end
      end
      bus_write(BASE, 32'h0, 4'hF);
      tick(4);
   endtask

   task automatic test_disable;
      logic [31:0] got, ev;
      int n;
      bus_write(BASE + 32'h4, 32'd100, 4'hF);
      bus_write(BASE, 32'h1, 4'hF);
      // The clearing write lands two edges after the poll sample, so 42 here leaves 40
      n = 0;
      bus_read(BASE + 32'h8, got);
      while (got != 32'd42 && n < 200) begin
         tick(1);
         bus_read(BASE + 32'h8, got);
         n++;
      end
      exp_q.push_back(32'd42);
      ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL disable_reach got %h exp %h", got, ev); end
      bus_write(BASE, 32'h0, 4'hF);
      tick(3);
      exp_q.push_back(32'd40);
      exp_q.push_back('0);
      bus_read(BASE + 32'h8, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL disable_count got %h exp %h", got, ev); end
      got = {31'b0, irq}; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL disable_irq got %h exp %h", got, ev); end
      tick(5);
      exp_q.push_back(32'd40);
      bus_read(BASE + 32'h8, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL disable_count_hold got %h exp %h", got, ev); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] got, ev;
      int n;
      bus_write(BASE + 32'h4, 32'd100, 4'hF);
      bus_write(BASE, 32'h9, 4'hF);
      n = 0;
      bus_read(BASE + 32'h8, got);
      while (got != 32'd10 && n < 200) begin
         tick(1);
         bus_read(BASE + 32'h8, got);
         n++;
      end
      exp_q.push_back(32'd10);
      ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL midreset_reach got %h exp %h", got, ev); end
      #2;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('0);
         bus_read(BASE + 32'(4 * i), got); ev = exp_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL midreset_reg%0d got %h exp %h", i, got, ev); end
      end
      exp_q.push_back('0);
      got = {31'b0, irq}; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL midreset_irq got %h exp %h", got, ev); end
      @(negedge clk);
      reset = 1'b1;
      tick(3);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('0);
         bus_read(BASE + 32'(4 * i), got); ev = exp_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL postreset_reg%0d got %h exp %h", i, got, ev); end
      end
   endtask

   task automatic test_decode;
      logic [31:0] got, ev;
      bus_write(BASE + 32'h4, 32'h12345678, 4'hF);
      bus_write(BASE + 32'h10, 32'hFFFFFFFF, 4'hF);
      bus_write(BASE + 32'h10, 32'hFFFFFFFF, 4'hF);
      exp_q.push_back('0);
      exp_q.push_back(32'h12345678);
      exp_q.push_back('0);
      exp_q.push_back('0);
      bus_read(BASE + 32'h10, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL decode_outside_rdata got %h exp %h", got, ev); end
      bus_read(BASE + 32'h4, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL decode_preset got %h exp %h", got, ev); end
      bus_read(BASE, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL decode_ctrl got %h exp %h", got, ev); end
      bus_read(BASE + 32'h8, got); ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL decode_count got %h exp %h", got, ev); end
   endtask

   initial begin
      addr = '0; wdata = '0; byteen = '0; reset = 1'b0;
      test_reset;
      test_byte_lane;
      test_oneshot;
      test_zero_preset;
      test_auto_reload;
      test_disable;
      test_reset_mid;
      test_decode;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
